// File: rtl/psd_sqrt_pkg.sv
// rtl/psd_sqrt_pkg.sv - shared types and constants for the sqrt core sequencer
package psd_sqrt_pkg;

  // Default operand width of the core; instances may override NBITSIN locally.
  localparam int NBITSIN_DEF = 32;
  localparam int NITER       = NBITSIN_DEF / 2;
  localparam int CNT_W       = $clog2(NITER);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    ITER    = 3'd2,
    STOP    = 3'd3,
    CAPTURE = 3'd4,
    HOLD    = 3'd5
  } state_e;

endpackage

// File: rtl/sqrt_seq_ctrl.sv
// rtl/sqrt_seq_ctrl.sv - operand/result sequencer for the bit-serial sqrt core
module sqrt_seq_ctrl
  import psd_sqrt_pkg::*;
#(
  parameter int NBITSIN = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NBITSIN-1:0]     in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NBITSIN/2-1:0]   out_data,
  output logic                   core_start,
  output logic                   core_stop,
  output logic [NBITSIN-1:0]     core_xin,
  input  logic [NBITSIN/2-1:0]   core_sqrt,
  output logic                   busy
);

  // One result bit per core cycle; the counter only has to reach NITER_L-1.
  localparam int NITER_L = NBITSIN / 2;
  localparam int CW      = (NITER_L > 1) ? $clog2(NITER_L) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NITER_L - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NBITSIN-1:0]     xin_q, xin_d;
  logic [NBITSIN/2-1:0]   res_q, res_d;
  logic                   accept;

  // HOLD accepts a new operand only in the same cycle its result is taken,
  // which makes in_ready combinationally dependent on out_ready.
  assign in_ready   = !reset && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == HOLD);
  assign out_data   = res_q;
  assign core_start = (state_q == START);
  assign core_stop  = (state_q == STOP);
  assign core_xin   = xin_q;
  assign busy       = (state_q != IDLE) && (state_q != HOLD);

  // Next-state, counter and datapath register selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xin_d   = xin_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          xin_d   = in_data;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        if (cnt_q == CNT_LAST) begin
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        res_d   = core_sqrt;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (accept) begin
            xin_d   = in_data;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any result in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xin_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xin_q   <= xin_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// tb/tb_sqrt_seq_ctrl.sv - self-checking bench for sqrt_seq_ctrl with a bit-serial core model
module tb_sqrt_seq_ctrl;
  import psd_sqrt_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  // 32-bit instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, core_xin;
  logic [15:0] out_data, core_sqrt;
  logic        core_start, core_stop, busy;

  // 8-bit instance
  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  in_data8, core_xin8;
  logic [3:0]  out_data8, core_sqrt8;
  logic        core_start8, core_stop8, busy8;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sqrt_seq_ctrl #(.NBITSIN(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_start(core_start), .core_stop(core_stop), .core_xin(core_xin),
    .core_sqrt(core_sqrt), .busy(busy)
  );

  sqrt_seq_ctrl #(.NBITSIN(8)) dut8 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .core_start(core_start8), .core_stop(core_stop8), .core_xin(core_xin8),
    .core_sqrt(core_sqrt8), .busy(busy8)
  );

  // Bit-serial restoring sqrt core: start loads/clears, NITER edges decide bits,
  // stop copies the partial root into the output register.
  logic [31:0] cx  = '0;
  logic [15:0] cr  = '0;
  logic [15:0] csq = '0;
  int          ck  = 0;
  always @(posedge clock) begin : core32
    logic [15:0] trial;
    trial = cr | (16'd1 << (ck - 1));
    if (core_start) begin
      cx <= core_xin; cr <= '0; ck <= 16;
    end else if (ck > 0) begin
      if (32'(trial) * 32'(trial) <= cx) cr <= trial;
      ck <= ck - 1;
    end
    if (core_stop) csq <= cr;
  end
  assign core_sqrt = csq;

  logic [7:0] cx8  = '0;
  logic [3:0] cr8  = '0;
  logic [3:0] csq8 = '0;
  int         ck8  = 0;
  always @(posedge clock) begin : core8
    logic [3:0] trial8;
    trial8 = cr8 | (4'd1 << (ck8 - 1));
    if (core_start8) begin
      cx8 <= core_xin8; cr8 <= '0; ck8 <= 4;
    end else if (ck8 > 0) begin
      if (8'(trial8) * 8'(trial8) <= cx8) cr8 <= trial8;
      ck8 <= ck8 - 1;
    end
    if (core_stop8) csq8 <= cr8;
  end
  assign core_sqrt8 = csq8;

  // Monitor for the 32-bit instance, sampled mid-cycle.
  int          acc_cnt = 0, start_cnt = 0, stop_cnt = 0, xin_change = 0;
  int          last_acc = 0, last_start = 0, last_stop = 0, last_rise = 0;
  logic        ov_prev = 1'b0, busy_prev = 1'b0;
  logic [31:0] xin_prev = '0;
  int          acc_q[$];
  logic [15:0] res_q[$];
  always @(negedge clock) begin
    if (in_valid && in_ready) begin acc_cnt++; last_acc = cyc; acc_q.push_back(cyc); end
    if (core_start) begin start_cnt++; last_start = cyc; end
    if (core_stop) begin stop_cnt++; last_stop = cyc; end
    if (out_valid && !ov_prev) last_rise = cyc;
    if (out_valid && out_ready) res_q.push_back(out_data);
    if (busy && busy_prev && core_xin !== xin_prev) xin_change++;
    ov_prev   = out_valid;
    busy_prev = busy;
    xin_prev  = core_xin;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; presents op until accepted, drops in_valid after the accept edge.
  task automatic send32(input logic [31:0] op);
    int n0 = acc_cnt;
    int k  = 0;
    in_valid = 1'b1; in_data = op;
    while (acc_cnt == n0 && k < 300) begin @(negedge clock); #1; k++; end
    chk("accept_timeout", 64'(acc_cnt != n0), 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out32();
    int k = 0;
    while (!out_valid && k < 300) begin @(negedge clock); #1; k++; end
    chk("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  typedef struct {
    logic [31:0] op;
    logic [15:0] res;
  } vec_t;

  typedef struct {
    logic [7:0] op;
    logic [3:0] res;
  } vec8_t;

  vec_t  vecs[5];
  vec_t  b2b[4];
  vec8_t v8[2];

  initial begin
    int s0, sc, n0, r0, k, acc8, rise8;
    int ov_bad, od_bad, ir_bad;

    vecs[0] = '{32'd144,        16'd12};
    vecs[1] = '{32'hFFFF_FFFF,  16'hFFFF};
    vecs[2] = '{32'd0,          16'd0};
    vecs[3] = '{32'h4000_0000,  16'h8000};
    vecs[4] = '{32'd15,         16'd3};
    b2b[0]  = '{32'd4,          16'd2};
    b2b[1]  = '{32'd99,         16'd9};
    b2b[2]  = '{32'd10000,      16'd100};
    b2b[3]  = '{32'd1000001,    16'd1000};
    v8[0]   = '{8'd200, 4'd14};
    v8[1]   = '{8'd255, 4'd15};

    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;

    // Reset state
    @(negedge clock); #1;
    chk("in_ready_during_reset", 64'(in_ready), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock); #1;
    chk("rst_in_ready",  64'(in_ready),   64'd1);
    chk("rst_out_valid", 64'(out_valid),  64'd0);
    chk("rst_busy",      64'(busy),       64'd0);
    chk("rst_start",     64'(core_start), 64'd0);
    chk("rst_stop",      64'(core_stop),  64'd0);
    chk("rst_xin",       64'(core_xin),   64'd0);
    chk("rst_out_data",  64'(out_data),   64'd0);
    @(posedge clock); #1;

    // Single operands with timing
    res_q.delete();
    for (int i = 0; i < 5; i++) begin
      send32(vecs[i].op);
      wait_out32();
      chk($sformatf("vec%0d_data", i),      64'(out_data),              64'(vecs[i].res));
      chk($sformatf("vec%0d_start_lat", i), 64'(last_start - last_acc), 64'd1);
      chk($sformatf("vec%0d_stop_lat", i),  64'(last_stop - last_acc),  64'd18);
      chk($sformatf("vec%0d_valid_lat", i), 64'(last_rise - last_acc),  64'd20);
      @(posedge clock); #1;
    end
    chk("vec_result_count", 64'(res_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < res_q.size(); i++)
      chk($sformatf("vec_order%0d", i), 64'(res_q[i]), 64'(vecs[i].res));

    // Back-to-back with in_valid held
    res_q.delete(); acc_q.delete();
    s0 = start_cnt;
    for (int i = 0; i < 4; i++) send32(b2b[i].op);
    k = 0;
    while (res_q.size() < 4 && k < 300) begin @(negedge clock); #1; k++; end
    chk("b2b_result_count", 64'(res_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < res_q.size(); i++)
      chk($sformatf("b2b_data%0d", i), 64'(res_q[i]), 64'(b2b[i].res));
    for (int i = 1; i < 4 && i < acc_q.size(); i++)
      chk($sformatf("b2b_interval%0d", i), 64'(acc_q[i] - acc_q[i-1]), 64'd20);
    chk("b2b_starts", 64'(start_cnt - s0), 64'd4);
    @(posedge clock); #1;

    // Backpressure
    out_ready = 1'b0;
    res_q.delete();
    send32(32'd50000);
    wait_out32();
    chk("bp_first_data", 64'(out_data), 64'd223);
    @(posedge clock); #1;
    in_valid = 1'b1; in_data = 32'd625;
    s0 = start_cnt; n0 = acc_cnt;
    ov_bad = 0; od_bad = 0; ir_bad = 0;
    repeat (50) begin
      @(negedge clock); #1;
      if (!out_valid) ov_bad++;
      if (out_data !== 16'd223) od_bad++;
      if (in_ready) ir_bad++;
    end
    chk("bp_out_valid_drop", 64'(ov_bad), 64'd0);
    chk("bp_out_data_change", 64'(od_bad), 64'd0);
    chk("bp_in_ready_high", 64'(ir_bad), 64'd0);
    chk("bp_extra_start", 64'(start_cnt - s0), 64'd0);
    chk("bp_no_accept", 64'(acc_cnt - n0), 64'd0);
    chk("bp_no_handshake", 64'(res_q.size()), 64'd0);
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(negedge clock); #1;
    chk("bp_release_accept", 64'(acc_cnt - n0), 64'd1);
    chk("bp_release_handshake", 64'(res_q.size()), 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    wait_out32();
    chk("bp_next_data", 64'(out_data), 64'd25);
    chk("bp_next_valid_lat", 64'(last_rise - last_acc), 64'd20);
    @(posedge clock); #1;

    // Reset while ITER counter is 7
    send32(32'd10000);
    sc = stop_cnt; r0 = last_rise;
    repeat (8) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock); #1;
    chk("mid_rst_busy",      64'(busy),       64'd0);
    chk("mid_rst_out_valid", 64'(out_valid),  64'd0);
    chk("mid_rst_in_ready",  64'(in_ready),   64'd1);
    chk("mid_rst_start",     64'(core_start), 64'd0);
    repeat (30) @(negedge clock);
    #1;
    chk("mid_rst_no_stop",  64'(stop_cnt - sc), 64'd0);
    chk("mid_rst_no_valid", 64'(last_rise - r0), 64'd0);
    @(posedge clock); #1;
    send32(32'd81);
    wait_out32();
    chk("post_rst_data", 64'(out_data), 64'd9);
    chk("post_rst_valid_lat", 64'(last_rise - last_acc), 64'd20);
    @(posedge clock); #1;

    chk("xin_stable_while_busy", 64'(xin_change), 64'd0);

    // NBITSIN=8 instance
    for (int i = 0; i < 2; i++) begin
      in_valid8 = 1'b1; in_data8 = v8[i].op;
      k = 0;
      do begin @(negedge clock); #1; k++; end while (!in_ready8 && k < 50);
      acc8 = cyc;
      chk($sformatf("n8_accept%0d", i), 64'(in_ready8), 64'd1);
      @(posedge clock); #1;
      in_valid8 = 1'b0;
      k = 0;
      while (!out_valid8 && k < 50) begin @(negedge clock); #1; k++; end
      rise8 = cyc;
      chk($sformatf("n8_valid%0d", i), 64'(out_valid8), 64'd1);
      chk($sformatf("n8_data%0d", i), 64'(out_data8), 64'(v8[i].res));
      chk($sformatf("n8_valid_lat%0d", i), 64'(rise8 - acc8), 64'd8);
      @(posedge clock); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sqrt_seq_ctrl.md
Name: sqrt_seq_ctrl

Overview:
- Initiator/sequencer for the team's iterative bit-serial square-root core, which uses a start/stop pulse interface.
- Takes operands over a valid/ready input stream and drives the core's start, xin and stop pins with exact timing.
- Captures the core's sqrt output and presents it on a valid/ready output stream with backpressure.
- Sits between the datapath fabric and one sqrt core instance; the core is external to this block.

Parameters:
NBITSIN, 32, operand width; even, range 4-64
NITER, NBITSIN/2, iterations the core needs (one result bit per cycle); derived, not overridden

Ports:
clock  input  1  master clock, rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  operand available
in_ready  output  1  block can accept operand this cycle
in_data  input  NBITSIN  unsigned operand
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_data  output  NBITSIN/2  unsigned floor(sqrt(operand))
core_start  output  1  one-cycle start pulse to core
core_stop  output  1  one-cycle stop pulse to core (loads core output register)
core_xin  output  NBITSIN  registered operand to core, stable START..STOP
core_sqrt  input  NBITSIN/2  core output register
busy  output  1  high in any state except IDLE and HOLD

Behaviour:
- Reset values: in_ready=0 during the reset cycle, then 1 in IDLE. out_valid=0, out_data=0, core_start=0, core_stop=0, core_xin=0, busy=0. State=IDLE, counter=0.
- Core timing contract:
  - Start in cycle S loads the operand and clears the core.
  - The core decides one bit per edge over the NITER edges ending cycles S+1..S+NITER.
  - Stop must be high in cycle S+NITER+1.
  - core_sqrt is valid from cycle S+NITER+2.
- States:
  - IDLE: in_ready=1. On in_valid, register in_data into core_xin and go to START.
  - START: core_start=1 for exactly one cycle; counter<=0; go to ITER.
  - ITER: counter increments each cycle. After NITER cycles (counter==NITER-1), go to STOP.
  - STOP: core_stop=1 for exactly one cycle; go to CAPTURE.
  - CAPTURE: out_data<=core_sqrt; go to HOLD.
  - HOLD: out_valid=1. out_data is held stable until out_ready.
    - On out_ready without in_valid, go to IDLE.
    - On out_ready with in_valid (in_ready=1 in this case), latch the new operand and go directly to START. Zero bubble.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). This is a combinational dependency on out_ready, documented.
- Latency: operand accepted in cycle T gives core_start in T+1, core_stop in T+NITER+2, out_valid rising in T+NITER+4 (T+20 for NBITSIN=32).
- Throughput: one result per NITER+4 cycles with out_ready held high.
- Stall: out_valid stays high and out_data stays constant indefinitely while out_ready=0. No new operand is accepted.
- core_xin changes only on an accept handshake; it is never modified during START..CAPTURE.
- in_valid outside IDLE/HOLD is ignored; the upstream holds it per the valid/ready rule.
- Reset mid-operation (any state) returns the block to IDLE and forces start/stop/out_valid low next cycle. A partially computed result is discarded. No stop pulse is issued after reset.
- Counter width: $clog2(NITER) bits minimum; wrap-around is not reachable because exit is at NITER-1.
- Widths: all data unsigned; no sign extension; out_data width exactly NBITSIN/2.

Decomposition:
- Shared package psd_sqrt_pkg holds:
  - state enum (IDLE, START, ITER, STOP, CAPTURE, HOLD)
  - localparam NITER
  - localparam CNT_W = $clog2(NITER)
- The package is reused by the core wrapper and the bench.
- No sub-module is required; the iteration counter stays inline.
- Bench instantiates sqrt_seq_ctrl with the existing sqrt core attached to the core_* pins.

Test Plan:
- Send 144 with out_ready=1 -> core_start 1 cycle after accept, core_stop 18 cycles after accept, out_valid rises 20 cycles after accept with out_data=12.
- Send 0xFFFFFFFF -> 0xFFFF. Send 0 -> 0. Send 0x40000000 -> 0x8000. Send 15 -> 3. Each is exact floor and appears in order.
- Back-to-back: in_valid held with 4 operands, out_ready=1 -> results every 20 cycles; HOLD->START without IDLE; no lost or duplicated result.
- Backpressure: out_ready=0 for 50 cycles after out_valid -> out_data constant, in_ready=0, no extra core_start. Release -> one handshake, then the next operand is accepted.
- Reset asserted in ITER (counter=7) -> next cycle state IDLE, out_valid=0, core_stop never pulses. New operand 81 -> 9 with normal latency.
- NBITSIN=8: operand 200 -> out_data=14, out_valid 8 cycles after accept. Operand 255 -> 15.
